conv_tensor_mem: RTL and testbench

//  Shared 4-D tensor store for the conv datapath. One instance serves as activation/output memory
//  (index_3 tied to 0; entry, y, x) and one as weight memory (in, out, ky, kx).
//  One write port and one independent read port; words are opaque DATA_SIZE-bit values
//  (IEEE-754 doubles at the default width).

---
 rtl/conv_tensor_mem.sv | 81 ++++++++
 tb/tb_conv_tensor_mem.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/conv_tensor_mem.sv
// conv_tensor_mem: 4-D tensor register file, one write port, one registered read port, sticky range error; trace via CONV_TENSOR_MEM_TRACE_EN
module conv_tensor_mem #(
  parameter string NAME      = "CONV_TENSOR_MEM",
  parameter int    DATA_SIZE = 64,
  parameter int    DIM3      = 1,
  parameter int    DIM2      = 1,
  parameter int    DIM1      = 5,
  parameter int    DIM0      = 5,
  parameter int    DEPTH     = DIM3 * DIM2 * DIM1 * DIM0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic [15:0]          index_3,
  input  logic [15:0]          index_2,
  input  logic [15:0]          index_1,
  input  logic [15:0]          index_0,
  input  logic [15:0]          read_index_3,
  input  logic [15:0]          read_index_2,
  input  logic [15:0]          read_index_1,
  input  logic [15:0]          read_index_0,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 addr_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  if (DEPTH != DIM3 * DIM2 * DIM1 * DIM0) begin : g_depth_chk
    $error("%s: DEPTH is derived from the DIMs and must not be overridden", NAME);
  end
  function automatic logic [31:0] lin(input logic [15:0] a3, a2, a1, a0);
    return ((32'(a3) * 32'(DIM2) + 32'(a2)) * 32'(DIM1) + 32'(a1)) * 32'(DIM0) + 32'(a0);
  endfunction
  function automatic logic in_rng(input logic [15:0] a3, a2, a1, a0);
    return 32'(a3) < 32'(DIM3) && 32'(a2) < 32'(DIM2) && 32'(a1) < 32'(DIM1) && 32'(a0) < 32'(DIM0);
  endfunction
  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [DATA_SIZE-1:0] mem_d [DEPTH];
  logic [DATA_SIZE-1:0] out_q, out_d;
  logic                 err_q, err_d;
  logic [31:0]          wr_lin, rd_lin;
  logic                 wr_ok, rd_ok;
  assign wr_lin = lin(index_3, index_2, index_1, index_0);
  assign rd_lin = lin(read_index_3, read_index_2, read_index_1, read_index_0);
  // The linear bound is implied by the field checks; it also keeps every address bit in use
  assign wr_ok  = in_rng(index_3, index_2, index_1, index_0) && wr_lin < 32'(DEPTH);
  assign rd_ok  = in_rng(read_index_3, read_index_2, read_index_1, read_index_0) && rd_lin < 32'(DEPTH);
  // Next state: read-first from the current array, accept in-range writes, latch any range error
  always_comb begin
    mem_d = mem_q;
    if (write && wr_ok) mem_d[wr_lin[AW-1:0]] = in_data;
    out_d = rd_ok ? mem_q[rd_lin[AW-1:0]] : '0;
    err_d = err_q | (write & ~wr_ok) | ~rd_ok;
  end
  // Array, read register and sticky error with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end
  assign out_data = out_q;
  assign addr_err = err_q;
`ifdef CONV_TENSOR_MEM_TRACE_EN
  // Simulation-only log of accepted writes and rejected accesses
  always @(posedge clk) begin
    if (rst_n) begin
      if (write && wr_ok)
        $display("%s write [%0d][%0d][%0d][%0d] = %f", NAME, index_3, index_2, index_1, index_0, $bitstoreal(64'(in_data)));
      if (write && !wr_ok)
        $display("%s ADDR ERR write [%0d][%0d][%0d][%0d]", NAME, index_3, index_2, index_1, index_0);
      if (!rd_ok)
        $display("%s ADDR ERR read [%0d][%0d][%0d][%0d]", NAME, read_index_3, read_index_2, read_index_1, read_index_0);
    end
  end
`endif
endmodule

// File: tb/tb_conv_tensor_mem.sv
// tb_conv_tensor_mem: random and directed checks of two memory shapes against a keyed reference store
module tb_conv_tensor_mem;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr [2];
  logic [63:0] din [2];
  logic [15:0] wi [2][4];
  logic [15:0] ri [2][4];
  logic [63:0] dout [2];
  logic        aerr [2];
  int          errors = 0;
  int          checks = 0;
  int          dims [2][4] = '{'{5, 5, 1, 1}, '{3, 3, 3, 2}};
  logic [63:0] m0 [logic [63:0]];
  logic [63:0] m1 [logic [63:0]];
  logic        em [2];

  always #5 clk = ~clk;

  conv_tensor_mem #(.NAME("ACT_MEM"), .DATA_SIZE(64), .DIM3(1), .DIM2(1), .DIM1(5), .DIM0(5)) u_act (
    .clk(clk), .rst_n(rst_n), .write(wr[0]), .in_data(din[0]),
    .index_3(wi[0][3]), .index_2(wi[0][2]), .index_1(wi[0][1]), .index_0(wi[0][0]),
    .read_index_3(ri[0][3]), .read_index_2(ri[0][2]), .read_index_1(ri[0][1]), .read_index_0(ri[0][0]),
    .out_data(dout[0]), .addr_err(aerr[0]));

  conv_tensor_mem #(.NAME("WGT_MEM"), .DATA_SIZE(64), .DIM3(2), .DIM2(3), .DIM1(3), .DIM0(3)) u_wgt (
    .clk(clk), .rst_n(rst_n), .write(wr[1]), .in_data(din[1]),
    .index_3(wi[1][3]), .index_2(wi[1][2]), .index_1(wi[1][1]), .index_0(wi[1][0]),
    .read_index_3(ri[1][3]), .read_index_2(ri[1][2]), .read_index_1(ri[1][1]), .read_index_0(ri[1][0]),
    .out_data(dout[1]), .addr_err(aerr[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] key(input logic [15:0] f [4]);
    return {f[3], f[2], f[1], f[0]};
  endfunction

  function automatic bit rng(input int n, input logic [15:0] f [4]);
    for (int i = 0; i < 4; i++) if (int'(f[i]) >= dims[n][i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] get(input int n, input logic [63:0] k);
    if (n == 0) return m0.exists(k) ? m0[k] : 64'd0;
    return m1.exists(k) ? m1[k] : 64'd0;
  endfunction

  task automatic put(input int n, input logic [63:0] k, input logic [63:0] d);
    if (n == 0) m0[k] = d;
    else m1[k] = d;
  endtask

  task automatic set_w(input int n, input int a3, a2, a1, a0, input logic [63:0] d);
    wr[n] = 1'b1;
    din[n] = d;
    wi[n][3] = 16'(a3); wi[n][2] = 16'(a2); wi[n][1] = 16'(a1); wi[n][0] = 16'(a0);
  endtask

  task automatic set_r(input int n, input int a3, a2, a1, a0);
    ri[n][3] = 16'(a3); ri[n][2] = 16'(a2); ri[n][1] = 16'(a1); ri[n][0] = 16'(a0);
  endtask

  task automatic tick();
    logic [63:0] eo [2];
    for (int n = 0; n < 2; n++) begin
      if (rng(n, ri[n])) eo[n] = get(n, key(ri[n]));
      else begin
        eo[n] = 64'd0;
        em[n] = 1'b1;
      end
      if (wr[n]) begin
        if (rng(n, wi[n])) put(n, key(wi[n]), din[n]);
        else em[n] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("out%0d", n), dout[n], eo[n]);
      chk($sformatf("err%0d", n), 64'(aerr[n]), 64'(em[n]));
      wr[n] = 1'b0;
    end
  endtask

  initial begin
    int k;
    for (int n = 0; n < 2; n++) begin
      wr[n] = 1'b0; din[n] = '0; em[n] = 1'b0;
      set_r(n, 0, 0, 0, 0);
      wi[n][3] = '0; wi[n][2] = '0; wi[n][1] = '0; wi[n][0] = '0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      chk("rst_out", dout[n], 64'd0);
      chk("rst_err", 64'(aerr[n]), 64'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    set_w(0, 0, 0, 1, 2, $realtobits(2.5));
    tick();
    set_r(0, 0, 0, 1, 2);
    tick();
    chk("wr_rd_2p5", dout[0], $realtobits(2.5));
    k = 0;
    for (int a3 = 0; a3 < 2; a3++)
      for (int a2 = 0; a2 < 3; a2++)
        for (int a1 = 0; a1 < 3; a1++)
          for (int a0 = 0; a0 < 3; a0++) begin
            set_w(1, a3, a2, a1, a0, 64'(k + 100));
            tick();
            k++;
          end
    k = 0;
    for (int a3 = 0; a3 < 2; a3++)
      for (int a2 = 0; a2 < 3; a2++)
        for (int a1 = 0; a1 < 3; a1++)
          for (int a0 = 0; a0 < 3; a0++) begin
            set_r(1, a3, a2, a1, a0);
            tick();
            chk("map4d", dout[1], 64'(k + 100));
            k++;
          end
    chk("map4d_err", 64'(aerr[1]), 64'd0);
    set_r(0, 0, 0, 0, 0);
    set_w(0, 0, 0, 0, 0, $realtobits(1.0));
    tick();
    set_w(0, 0, 0, 0, 0, $realtobits(7.0));
    tick();
    chk("collide_old", dout[0], $realtobits(1.0));
    tick();
    chk("collide_new", dout[0], $realtobits(7.0));
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if ($urandom_range(0, 1) == 1)
          set_w(n, $urandom_range(0, dims[n][3] - 1), $urandom_range(0, dims[n][2] - 1),
                $urandom_range(0, dims[n][1] - 1), $urandom_range(0, dims[n][0] - 1), {$urandom, $urandom});
        set_r(n, $urandom_range(0, dims[n][3] - 1), $urandom_range(0, dims[n][2] - 1),
              $urandom_range(0, dims[n][1] - 1), $urandom_range(0, dims[n][0] - 1));
      end
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out0", dout[0], 64'd0);
    chk("arst_out1", dout[1], 64'd0);
    m0.delete();
    m1.delete();
    em[0] = 1'b0;
    em[1] = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    set_r(0, 0, 0, 2, 3);
    tick();
    chk("post_rst_rd", dout[0], 64'd0);
    chk("post_rst_err", 64'(aerr[0]), 64'd0);
    set_r(0, 0, 0, 0, 0);
    set_w(0, 0, 0, 0, 0, 64'hDEAD_BEEF_0000_0001);
    tick();
    set_w(0, 0, 0, 5, 0, 64'h1234_5678_9ABC_DEF0);
    tick();
    chk("oob_wr_err", 64'(aerr[0]), 64'd1);
    for (int a1 = 0; a1 < 5; a1++)
      for (int a0 = 0; a0 < 5; a0++) begin
        set_r(0, 0, 0, a1, a0);
        tick();
      end
    set_r(0, 0, 1, 0, 0);
    tick();
    chk("oob_rd_zero", dout[0], 64'd0);
    set_r(1, 1, 2, 2, 2);
    tick();
    set_r(1, 2, 0, 0, 0);
    tick();
    chk("oob_rd1_zero", dout[1], 64'd0);
    chk("oob_rd1_err", 64'(aerr[1]), 64'd1);
    set_r(1, 0, 0, 0, 0);
    tick();
    chk("err_sticky", 64'(aerr[1]), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
